// File: rtl/uart_mmio_pkg.sv
// Shared register map, STATUS/CTRL bit positions and FSM state encodings for the
// memory-mapped UART.
package uart_mmio_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_BAUD   = 4'h8;
    localparam logic [3:0] ADDR_CTRL   = 4'hC;

    localparam int unsigned STAT_TXFULL  = 0;
    localparam int unsigned STAT_TXEMPTY = 1;
    localparam int unsigned STAT_TXBUSY  = 2;
    localparam int unsigned STAT_RXV     = 3;
    localparam int unsigned STAT_OVR     = 4;
    localparam int unsigned STAT_FE      = 5;
    localparam int unsigned STAT_W       = 6;

    localparam int unsigned CTRL_RXIE = 0;
    localparam int unsigned CTRL_TXIE = 1;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO holding bytes queued for transmission. A push on a full FIFO is
// accepted only when a pop happens on the same edge.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX FIFO plus serializer, synchronized RX deserializer with a
// one-byte holding register, STATUS/BAUD/CTRL registers and a level interrupt.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int unsigned DIV_RESET = 434,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned TX_DEPTH  = 8
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iCE,
    input  logic        iRD,
    input  logic        iWR,
    input  logic [3:0]  iADDR,
    input  logic [31:0] iDATA,
    output logic [31:0] oDATA,
    output logic        oIRQ,
    input  logic        iRXD,
    output logic        oTXD
);

    localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);
    localparam logic [DIV_W-1:0] DivMin = DIV_W'(2);

    // Bus decode
    logic rd_en, wr_en, data_rd, data_wr, stat_wr, baud_wr, ctrl_wr;
    assign rd_en   = iCE & iRD;
    assign wr_en   = iCE & iWR;
    assign data_rd = rd_en & (iADDR == ADDR_DATA);
    assign data_wr = wr_en & (iADDR == ADDR_DATA);
    assign stat_wr = wr_en & (iADDR == ADDR_STATUS);
    assign baud_wr = wr_en & (iADDR == ADDR_BAUD);
    assign ctrl_wr = wr_en & (iADDR == ADDR_CTRL);

    logic [DIV_W-1:0] baud_q, baud_wval;
    logic [1:0]       ctrl_q;
    logic             rxv_q, rxv_d, ovr_q, ovr_d, fe_q, fe_d;
    logic [7:0]       rx_byte_q, rx_byte_d;

    assign baud_wval = (iDATA[DIV_W-1:0] < DivMin) ? DivMin : iDATA[DIV_W-1:0];

    // TX FIFO
    logic       fifo_full, fifo_empty, tx_pop;
    logic [7:0] fifo_dout;

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (iCLK),
        .rst_n (iRST),
        .push  (data_wr),
        .pop   (tx_pop),
        .din   (iDATA[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // TX FSM
    tx_state_e        tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             txd_d, tx_tick, tx_busy;

    assign tx_tick = (tx_cnt_q == DivOne);
    assign tx_busy = (tx_state_q != TxIdle);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q - DivOne;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        txd_d      = 1'b1;
        case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = tx_cnt_q;
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_dout;
                    tx_cnt_d   = baud_q;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                txd_d = 1'b0;
                if (tx_tick) begin
                    tx_cnt_d   = baud_q;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TxData;
                end
            end
            TxData: begin
                txd_d = tx_shift_q[0];
                if (tx_tick) begin
                    tx_cnt_d   = baud_q;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TxStop;
                end
            end
            TxStop: begin
                if (tx_tick) begin
                    // Back-to-back frames: no idle bit when more data is queued.
                    if (!fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = fifo_dout;
                        tx_cnt_d   = baud_q;
                        tx_state_d = TxStart;
                    end else begin
                        tx_state_d = TxIdle;
                    end
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // RX synchronizer and FSM
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_tick, rx_done;

    assign rx_tick = (rx_cnt_q == DivOne);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q - DivOne;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = rx_cnt_q;
                if (rx_prev_q && !rx_s2_q) begin
                    rx_cnt_d   = baud_q >> 1;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_tick) begin
                    rx_cnt_d   = baud_q;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_tick) begin
                    rx_cnt_d   = baud_q;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_tick) begin
                    rx_done    = 1'b1;
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // Status flag next-state; set events win over a same-edge clear.
    logic rx_store, ovr_set;

    always_comb begin
        rx_store  = rx_done & rx_s2_q & (~rxv_q | data_rd);
        ovr_set   = (data_wr & fifo_full & ~tx_pop) | (rx_done & rx_s2_q & rxv_q & ~data_rd);
        rxv_d     = rxv_q & ~data_rd;
        rx_byte_d = rx_byte_q;
        if (rx_store) begin
            rxv_d     = 1'b1;
            rx_byte_d = rx_shift_q;
        end
        ovr_d = ovr_q & ~(stat_wr & iDATA[STAT_OVR]);
        if (ovr_set) ovr_d = 1'b1;
        fe_d = fe_q & ~(stat_wr & iDATA[STAT_FE]);
        if (rx_done && !rx_s2_q) fe_d = 1'b1;
    end

    logic [STAT_W-1:0] status;
    logic [31:0]       rd_mux;

    always_comb begin
        status               = '0;
        status[STAT_TXFULL]  = fifo_full;
        status[STAT_TXEMPTY] = fifo_empty;
        status[STAT_TXBUSY]  = tx_busy;
        status[STAT_RXV]     = rxv_q;
        status[STAT_OVR]     = ovr_q;
        status[STAT_FE]      = fe_q;
        case (iADDR)
            ADDR_DATA:   rd_mux = {24'b0, rx_byte_q};
            ADDR_STATUS: rd_mux = {{(32-STAT_W){1'b0}}, status};
            ADDR_BAUD:   rd_mux = {{(32-DIV_W){1'b0}}, baud_q};
            ADDR_CTRL:   rd_mux = {30'b0, ctrl_q};
            default:     rd_mux = 32'b0;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDATA      <= '0;
            oIRQ       <= 1'b0;
            oTXD       <= 1'b1;
            baud_q     <= DIV_W'(DIV_RESET);
            ctrl_q     <= '0;
            rxv_q      <= 1'b0;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
            rx_byte_q  <= '0;
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            if (rd_en)   oDATA  <= rd_mux;
            if (baud_wr) baud_q <= baud_wval;
            if (ctrl_wr) ctrl_q <= iDATA[1:0];
            oIRQ       <= (ctrl_q[CTRL_RXIE] & rxv_q)
                        | (ctrl_q[CTRL_TXIE] & fifo_empty & ~tx_busy);
            oTXD       <= txd_d;
            rxv_q      <= rxv_d;
            ovr_q      <= ovr_d;
            fe_q       <= fe_d;
            rx_byte_q  <= rx_byte_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            rx_s1_q    <= iRXD;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: bus reads and serial TX bytes are predicted by a
// flag-level model and checked by independent monitors.
module tb_uart_mmio;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    logic        rxd = 1'b1;
    logic        txd;

    always #5 clk = ~clk;

    uart_mmio #(
        .DIV_RESET (434),
        .DIV_W     (16),
        .TX_DEPTH  (8)
    ) dut (
        .iCLK  (clk),
        .iRST  (rst_n),
        .iCE   (ce),
        .iRD   (rd),
        .iWR   (wr),
        .iADDR (addr),
        .iDATA (wdata),
        .oDATA (rdata),
        .oIRQ  (irq),
        .iRXD  (rxd),
        .oTXD  (txd)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model: flags, held byte, baud, and the queues of expected outputs.
    bit          m_rxv = 0, m_ovr = 0, m_fe = 0;
    logic [7:0]  m_rxbyte = '0;
    int          m_baud = 434;
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic [7:0]  tx_exp_q[$];

    bit          tx_mon_en = 1;
    bit          tx_mon_busy = 0;
    logic [7:0]  tx_bits;
    logic        tx_stop;
    logic [7:0]  burst[10];
    logic [7:0]  rb;
    logic        rd_fire = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_line(input string name);
        n_total++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [31:0] status_exp(input bit full, input bit empty, input bit busy);
        return {26'b0, m_fe, m_ovr, m_rxv, busy, empty, full};
    endfunction

    // Read monitor: oDATA is valid one cycle after a read strobe.
    always @(posedge clk) rd_fire <= ce & rd;

    always @(negedge clk) begin
        if (rd_fire) begin
            if (rd_exp_q.size() == 0) fail_line("unexpected_read");
            else check(rd_name_q.pop_front(), rdata, rd_exp_q.pop_front());
        end
    end

    // Serial TX monitor: samples mid-bit and pops the expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_mon_en && rst_n && txd == 1'b0) begin
                tx_mon_busy = 1;
                repeat (m_baud / 2) @(negedge clk);
                if (tx_mon_en) check("tx_start_bit", {31'b0, txd}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (m_baud) @(negedge clk);
                    tx_bits[i] = txd;
                end
                repeat (m_baud) @(negedge clk);
                tx_stop = txd;
                if (tx_mon_en) begin
                    if (tx_exp_q.size() == 0) fail_line("tx_unexpected_frame");
                    else check("tx_byte", {24'b0, tx_bits}, {24'b0, tx_exp_q.pop_front()});
                    check("tx_stop_bit", {31'b0, tx_stop}, 32'd1);
                end
                tx_mon_busy = 0;
            end
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        ce = 1; wr = 1; addr = a; wdata = d;
        @(posedge clk); #1;
        ce = 0; wr = 0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        ce = 1; rd = 1; addr = a;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        @(posedge clk); #1;
        ce = 0; rd = 0;
    endtask

    task automatic read_data(input string name);
        bus_read(4'h0, {24'b0, m_rxbyte}, name);
        m_rxv = 0;
    endtask

    task automatic tx_push(input logic [7:0] b);
        tx_exp_q.push_back(b);
        bus_write(4'h0, {24'b0, b});
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            repeat (m_baud) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        if (!stop) m_fe = 1;
        else if (m_rxv) m_ovr = 1;
        else begin
            m_rxbyte = b;
            m_rxv = 1;
        end
    endtask

    task automatic wait_tx_drain();
        int budget = 4000;
        while ((tx_exp_q.size() != 0 || tx_mon_busy) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) fail_line("tx_drain_timeout");
        repeat (m_baud + 4) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_txd", {31'b0, txd}, 32'd1);
        check("reset_irq", {31'b0, irq}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;

        bus_read(4'h8, 32'd434, "reset_baud");
        bus_read(4'h4, status_exp(0, 1, 0), "reset_status");
        bus_read(4'hC, 32'd0, "reset_ctrl");
        bus_write(4'h8, 32'd4);
        m_baud = 4;

        // Single frame 0x55 with exact start latency
        @(posedge clk); #1;
        ce = 1; wr = 1; addr = 4'h0; wdata = 32'h55;
        tx_exp_q.push_back(8'h55);
        @(posedge clk); #1;
        ce = 0; wr = 0;
        @(negedge clk); check("t1_txd_at_n", {31'b0, txd}, 32'd1);
        @(negedge clk); check("t1_txd_at_n1", {31'b0, txd}, 32'd1);
        @(negedge clk); check("t1_txd_at_n2", {31'b0, txd}, 32'd0);
        bus_read(4'h4, status_exp(0, 1, 1), "t1_status_busy");
        wait_tx_drain();
        bus_read(4'h4, status_exp(0, 1, 0), "t1_status_done");

        // Burst of 10 pushes: 9 accepted, 10th overflows
        for (int i = 0; i < 10; i++) burst[i] = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        ce = 1; wr = 1; addr = 4'h0;
        for (int i = 0; i < 10; i++) begin
            wdata = {24'b0, burst[i]};
            if (i < 9) tx_exp_q.push_back(burst[i]);
            @(posedge clk); #1;
        end
        ce = 0; wr = 0;
        m_ovr = 1;
        bus_read(4'h4, status_exp(1, 0, 1), "t2_status_full_ovr");
        bus_write(4'h4, 32'h10);
        m_ovr = 0;
        bus_read(4'h4, status_exp(1, 0, 1), "t2_status_ovr_clr");
        wait_tx_drain();
        bus_read(4'h4, status_exp(0, 1, 0), "t2_status_drained");

        // RX byte, read, then overrun
        rx_frame(8'hA3, 1);
        bus_read(4'h4, status_exp(0, 1, 0), "t3_status_rxv");
        read_data("t3_data_a3");
        bus_read(4'h4, status_exp(0, 1, 0), "t3_status_rxv_clr");
        rb = 8'($urandom_range(0, 255));
        rx_frame(rb, 1);
        rx_frame(8'($urandom_range(0, 255)), 1);
        read_data("t3_data_kept");
        bus_read(4'h4, status_exp(0, 1, 0), "t3_status_ovr");
        bus_write(4'h4, 32'h30);
        m_ovr = 0; m_fe = 0;

        // Framing error and glitch rejection
        rx_frame(8'($urandom_range(0, 255)), 0);
        bus_read(4'h4, status_exp(0, 1, 0), "t4_status_fe");
        bus_write(4'h4, 32'h20);
        m_fe = 0;
        @(posedge clk); #1; rxd = 0;
        @(posedge clk); #1; rxd = 1;
        repeat (20) @(posedge clk);
        bus_read(4'h4, status_exp(0, 1, 0), "t4_status_glitch");

        // Interrupts
        bus_write(4'hC, 32'h3);
        repeat (2) @(negedge clk);
        check("t5_irq_tx_idle", {31'b0, irq}, 32'd1);
        tx_push(8'($urandom_range(0, 255)));
        repeat (2) @(negedge clk);
        check("t5_irq_drop", {31'b0, irq}, 32'd0);
        bus_write(4'hC, 32'h1);
        wait_tx_drain();
        check("t5_irq_rxie_only", {31'b0, irq}, 32'd0);
        rx_frame(8'($urandom_range(0, 255)), 1);
        check("t5_irq_rx", {31'b0, irq}, 32'd1);
        read_data("t5_data");
        repeat (2) @(negedge clk);
        check("t5_irq_rx_clr", {31'b0, irq}, 32'd0);
        bus_write(4'hC, 32'h0);

        // Reset mid-frame (all-zero byte so the line is low when reset hits)
        bus_write(4'h8, 32'd7);
        bus_write(4'hC, 32'h3);
        tx_mon_en = 0;
        bus_write(4'h0, 32'h00);
        repeat (15) @(posedge clk);
        #3;
        check("t6_txd_before_rst", {31'b0, txd}, 32'd0);
        rst_n = 0;
        #1;
        check("t6_txd_async", {31'b0, txd}, 32'd1);
        check("t6_rdata_rst", rdata, 32'd0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1;
        m_rxv = 0; m_ovr = 0; m_fe = 0; m_rxbyte = '0; m_baud = 434;
        bus_read(4'h8, 32'd434, "t6_baud");
        bus_read(4'hC, 32'd0, "t6_ctrl");
        bus_read(4'h4, status_exp(0, 1, 0), "t6_status");
        read_data("t6_data");
        repeat (20) @(negedge clk);
        check("t6_txd_idle", {31'b0, txd}, 32'd1);
        tx_mon_en = 1;
        bus_write(4'h8, 32'd0);
        bus_read(4'h8, 32'd2, "t6_baud_zero");
        bus_write(4'h8, 32'd1);
        bus_read(4'h8, 32'd2, "t6_baud_one");
        bus_write(4'h8, 32'd4);
        m_baud = 4;

        // Randomized mix of TX bursts, RX frames, reads and flag clears
        for (int it = 0; it < 8; it++) begin
            int nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) tx_push(8'($urandom_range(0, 255)));
            rx_frame(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
            wait_tx_drain();
            bus_read(4'h4, status_exp(0, 1, 0), "rnd_status");
            if ($urandom_range(0, 1) == 1) read_data("rnd_data");
            if ($urandom_range(0, 2) == 0) begin
                bus_write(4'h4, 32'h30);
                m_ovr = 0; m_fe = 0;
            end
        end

        repeat (5) @(posedge clk);
        check("rd_queue_drained", rd_exp_q.size(), 32'd0);
        check("tx_queue_drained", tx_exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
